nps_outmem_sched: RTL and testbench

NPS_OUTMEM_SCHED -- requirements
Module: nps_outmem_sched

---
 rtl/nps_outmem_pkg.sv | 14 +
 rtl/nps_outmem_arb.sv | 67 ++++++
 rtl/nps_outmem_sched.sv | 144 ++++++++++++++
 tb/tb_nps_outmem_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nps_outmem_pkg.sv
// Shared types and constants for the output-memory capture scheduler.
// Frame counter is present only when NPS_OUTMEM_SCHED_FRMCNT_EN is defined.
package nps_outmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FRM_CNT_W = 16;

endpackage

// File: rtl/nps_outmem_arb.sv
// Single-port RAM arbiter: stream writes always win, CPU reads fill idle cycles.
// Read result and ack come two cycles after the grant.
module nps_outmem_arb
  import nps_outmem_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DATA_NUM   = 300,
  parameter int ADR_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset_x,
  input  logic                  i_st_we,
  input  logic [ADR_WIDTH-1:0]  i_st_adr,
  input  logic [DATA_WIDTH-1:0] i_st_wdata,
  input  logic                  i_cpu_req,
  input  logic [ADR_WIDTH-1:0]  i_cpu_adr,
  output logic                  o_cpu_ack,
  output logic [DATA_WIDTH-1:0] o_cpu_data,
  output logic                  o_mem_we,
  output logic [ADR_WIDTH-1:0]  o_mem_adr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [ADR_WIDTH:0] LP_NUM = (ADR_WIDTH+1)'(DATA_NUM);

  logic                  w_oob;
  logic                  w_grant;
  logic                  r_vld_p1;
  logic                  r_oob_p1;
  logic                  r_ack_p2;
  logic [DATA_WIDTH-1:0] r_data_p2;

  assign w_oob   = ({1'b0, i_cpu_adr} >= LP_NUM);
  // The ack cycle also blocks a grant, so a request still held while ack is high is not re-served.
  assign w_grant = i_cpu_req & ~i_st_we & ~r_vld_p1 & ~r_ack_p2;

  always_comb begin
    o_mem_we    = i_st_we;
    o_mem_wdata = i_st_wdata;
    o_mem_adr   = '0;
    if (i_st_we)
      o_mem_adr = i_st_adr;
    else if (w_grant && !w_oob)
      o_mem_adr = i_cpu_adr;
  end

  // p1: RAM read in progress; p2: registered read data with ack
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_vld_p1  <= 1'b0;
      r_oob_p1  <= 1'b0;
      r_ack_p2  <= 1'b0;
      r_data_p2 <= '0;
    end else begin
      r_vld_p1 <= w_grant;
      r_oob_p1 <= w_grant & w_oob;
      r_ack_p2 <= r_vld_p1;
      if (r_vld_p1)
        r_data_p2 <= r_oob_p1 ? '0 : i_mem_rdata;
    end
  end

  assign o_cpu_ack  = r_ack_p2;
  assign o_cpu_data = r_data_p2;

endmodule

// File: rtl/nps_outmem_sched.sv
// Captures one frame of DATA_NUM stream words into RAM, sharing the RAM with CPU reads.
// Define NPS_OUTMEM_SCHED_FRMCNT_EN to enable the completed-frame counter on frm_cnt.
module nps_outmem_sched
  import nps_outmem_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DATA_NUM   = 300,
  parameter int ADR_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset_x,
  input  logic                  start,
  input  logic                  vi,
  input  logic                  fi,
  input  logic [DATA_WIDTH-1:0] datai,
  output logic                  vo,
  output logic                  fo,
  input  logic                  cpu_req,
  input  logic [ADR_WIDTH-1:0]  cpu_adr,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  mem_we,
  output logic [ADR_WIDTH-1:0]  mem_adr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  frm_err,
  output logic [FRM_CNT_W-1:0]  frm_cnt
);

  localparam logic [ADR_WIDTH-1:0] LP_LAST    = ADR_WIDTH'(DATA_NUM - 1);
  localparam logic [ADR_WIDTH-1:0] LP_ADR_ONE = ADR_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADR_WIDTH-1:0]  r_wr_cnt;
  logic [ADR_WIDTH-1:0]  w_wr_adr;
  logic                  w_st_we;
  logic                  w_arm;
  logic                  w_capt_done;
  logic                  r_vo;
  logic                  r_fo;
  logic                  r_done;
  logic                  r_frm_err;

  // A stray fi inside a frame does not restart it; that word keeps its normal slot.
  always_comb begin
    w_state_nxt = r_state;
    w_st_we     = 1'b0;
    w_arm       = 1'b0;
    w_capt_done = 1'b0;
    w_wr_adr    = r_wr_cnt + LP_ADR_ONE;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = ARM;
          w_arm       = 1'b1;
        end
      end
      ARM: begin
        if (vi && fi) begin
          w_st_we     = 1'b1;
          w_wr_adr    = '0;
          w_state_nxt = CAPT;
        end
      end
      CAPT: begin
        if (vi) begin
          w_st_we = 1'b1;
          if (w_wr_adr == LP_LAST) begin
            w_capt_done = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_state   <= IDLE;
      r_wr_cnt  <= '0;
      r_vo      <= 1'b0;
      r_fo      <= 1'b0;
      r_done    <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vo    <= vi;
      r_fo    <= fi;
      r_done  <= w_capt_done;
      if (w_st_we)
        r_wr_cnt <= w_wr_adr;
      if (w_arm)
        r_frm_err <= 1'b0;
      else if ((r_state == CAPT) && vi && fi)
        r_frm_err <= 1'b1;
    end
  end

  assign vo      = r_vo;
  assign fo      = r_fo;
  assign done    = r_done;
  assign frm_err = r_frm_err;
  assign busy    = (r_state == ARM) || (r_state == CAPT);

`ifdef NPS_OUTMEM_SCHED_FRMCNT_EN
  logic [FRM_CNT_W-1:0] r_frm_cnt;

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x)
      r_frm_cnt <= '0;
    else if (r_done)
      r_frm_cnt <= r_frm_cnt + FRM_CNT_W'(1);
  end

  assign frm_cnt = r_frm_cnt;
`else
  assign frm_cnt = '0;
`endif

  nps_outmem_arb #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_NUM   (DATA_NUM),
    .ADR_WIDTH  (ADR_WIDTH)
  ) u_arb (
    .clk         (clk),
    .reset_x     (reset_x),
    .i_st_we     (w_st_we),
    .i_st_adr    (w_wr_adr),
    .i_st_wdata  (datai),
    .i_cpu_req   (cpu_req),
    .i_cpu_adr   (cpu_adr),
    .o_cpu_ack   (cpu_ack),
    .o_cpu_data  (cpu_data),
    .o_mem_we    (mem_we),
    .o_mem_adr   (mem_adr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

endmodule

// File: tb/tb_nps_outmem_sched.sv
// Directed bench for nps_outmem_sched: frame capture, CPU reads, frame error and reset.
module tb_nps_outmem_sched;

`ifdef NPS_OUTMEM_SCHED_FRMCNT_EN
  localparam int FRMCNT_ON = 1;
`else
  localparam int FRMCNT_ON = 0;
`endif

  logic        clk;
  logic        reset_x;
  logic        start, vi, fi;
  logic [23:0] datai;
  logic        vo, fo;
  logic        cpu_req;
  logic [8:0]  cpu_adr;
  logic        cpu_ack;
  logic [23:0] cpu_data;
  logic        mem_we;
  logic [8:0]  mem_adr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic        busy, done, frm_err;
  logic [15:0] frm_cnt;

  logic [23:0] ram [0:511];

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  bit saw_adr300 = 0;
  bit ack_watch = 0;
  bit ack_seen = 0;

  typedef struct {
    logic [8:0]  adr;
    logic [8:0]  madr;
    logic [23:0] exp;
  } rd_vec_t;

  rd_vec_t rv [6];

  nps_outmem_sched dut (
    .clk       (clk),
    .reset_x   (reset_x),
    .start     (start),
    .vi        (vi),
    .fi        (fi),
    .datai     (datai),
    .vo        (vo),
    .fo        (fo),
    .cpu_req   (cpu_req),
    .cpu_adr   (cpu_adr),
    .cpu_ack   (cpu_ack),
    .cpu_data  (cpu_data),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .frm_err   (frm_err),
    .frm_cnt   (frm_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) ram[mem_adr] <= mem_wdata;
    mem_rdata <= ram[mem_adr];
    if (mem_adr == 9'd300) saw_adr300 = 1'b1;
  end

  always @(negedge clk) begin
    if (done) n_done++;
    if (ack_watch && cpu_ack) ack_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; leaves one idle cycle after the ack.
  task automatic cpu_read(input logic [8:0] adr, input logic [8:0] madr,
                          input logic [23:0] exp, input string nm);
    int  k;
    bit  got;
    cpu_req = 1'b1;
    cpu_adr = adr;
    #1;
    chk({nm, " mem_adr"}, 32'(mem_adr), 32'(madr));
    k = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (cpu_ack) got = 1'b1;
    end
    chk({nm, " latency"}, 32'(k), 32'd2);
    chk({nm, " data"}, 32'(cpu_data), 32'(exp));
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int nbad;
    logic pat [6];

    for (int a = 0; a < 512; a++) ram[a] = 24'hABCDEF;
    reset_x = 1'b0;
    start = 1'b0; vi = 1'b0; fi = 1'b0; datai = '0;
    cpu_req = 1'b0; cpu_adr = '0;

    rv[0] = '{9'd5,   9'd5,   24'd5};
    rv[1] = '{9'd0,   9'd0,   24'd0};
    rv[2] = '{9'd299, 9'd299, 24'd299};
    rv[3] = '{9'd300, 9'd0,   24'd0};
    rv[4] = '{9'd511, 9'd0,   24'd0};
    rv[5] = '{9'd150, 9'd150, 24'd150};

    repeat (3) @(negedge clk);
    chk("rst vo", 32'(vo), 0);
    chk("rst fo", 32'(fo), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst frm_err", 32'(frm_err), 0);
    chk("rst frm_cnt", 32'(frm_cnt), 0);
    chk("rst cpu_ack", 32'(cpu_ack), 0);
    chk("rst cpu_data", 32'(cpu_data), 0);
    reset_x = 1'b1;
    @(negedge clk);

    // Frame 1: datai = index
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("f1 busy armed", 32'(busy), 1);
    vi = 1'b1; fi = 1'b0; datai = 24'h777;
    #1;
    chk("f1 arm vi no fi we", 32'(mem_we), 0);
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      vi = 1'b1; fi = (i == 0); datai = 24'(i);
      if (i == 5) begin
        #1;
        chk("f1 w5 we", 32'(mem_we), 1);
        chk("f1 w5 adr", 32'(mem_adr), 5);
        chk("f1 w5 wdata", 32'(mem_wdata), 5);
      end
      @(negedge clk);
      if (i == 0) begin
        chk("f1 vo", 32'(vo), 1);
        chk("f1 fo", 32'(fo), 1);
      end
    end
    vi = 1'b0; fi = 1'b0;
    chk("f1 done pulse", 32'(done), 1);
    chk("f1 busy after", 32'(busy), 0);
    @(negedge clk);
    chk("f1 done cleared", 32'(done), 0);
    chk("f1 done count", 32'(n_done), 1);
    chk("f1 frm_cnt", 32'(frm_cnt), 32'(FRMCNT_ON));
    nbad = 0;
    for (int a = 0; a < 300; a++) if (ram[a] !== 24'(a)) nbad++;
    chk("f1 ram contents", 32'(nbad), 0);
    vi = 1'b1; fi = 1'b1; datai = 24'h555;
    #1;
    chk("done vi ignored", 32'(mem_we), 0);
    @(negedge clk);
    vi = 1'b0; fi = 1'b0;
    chk("done no rearm", 32'(busy), 0);

    for (int v = 0; v < 6; v++)
      cpu_read(rv[v].adr, rv[v].madr, rv[v].exp, $sformatf("rd%0d", v));

    // Held request: ack, then a new read starts the cycle after
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cpu_req = 1'b1; cpu_adr = 9'd10;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("held ack c%0d", k), 32'(cpu_ack), 32'(pat[k]));
    end
    chk("held data", 32'(cpu_data), 10);
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Frame 2: start with vi&fi in same cycle, fi at word 100, CPU read across a burst
    start = 1'b1; vi = 1'b1; fi = 1'b1; datai = 24'h999;
    #1;
    chk("f2 start+fi no write", 32'(mem_we), 0);
    @(negedge clk);
    start = 1'b0;
    chk("f2 busy armed", 32'(busy), 1);
    for (int i = 0; i < 300; i++) begin
      vi = 1'b1; fi = (i == 0 || i == 100); datai = 24'(1000 + i);
      if (i == 200) begin cpu_req = 1'b1; cpu_adr = 9'd5; end
      if (i >= 200 && i <= 209) begin
        #1;
        chk($sformatf("burst ack w%0d", i), 32'(cpu_ack), 0);
        chk($sformatf("burst adr w%0d", i), 32'(mem_adr), 32'(i));
      end
      @(negedge clk);
      if (i == 100) chk("f2 frm_err set", 32'(frm_err), 1);
      if (i == 209) begin
        vi = 1'b0; fi = 1'b0;
        #1;
        chk("gap grant adr", 32'(mem_adr), 5);
        @(negedge clk);
        chk("gap ack n+1", 32'(cpu_ack), 0);
        @(negedge clk);
        chk("gap ack n+2", 32'(cpu_ack), 1);
        chk("gap data", 32'(cpu_data), 1005);
        cpu_req = 1'b0;
        @(negedge clk);
      end
    end
    vi = 1'b0; fi = 1'b0;
    chk("f2 done pulse", 32'(done), 1);
    @(negedge clk);
    chk("f2 frm_err sticky", 32'(frm_err), 1);
    chk("f2 done count", 32'(n_done), 2);
    chk("f2 frm_cnt", 32'(frm_cnt), 32'(2 * FRMCNT_ON));
    chk("f2 ram100", 32'(ram[100]), 1100);
    chk("f2 ram299", 32'(ram[299]), 1299);
    nbad = 0;
    for (int a = 0; a < 300; a++) if (ram[a] !== 24'(1000 + a)) nbad++;
    chk("f2 ram contents", 32'(nbad), 0);
    chk("adr300 never driven", 32'(saw_adr300), 0);

    // Frame 3: start clears frm_err, then reset mid-frame with a read in flight
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("f3 frm_err cleared", 32'(frm_err), 0);
    chk("f3 busy", 32'(busy), 1);
    for (int i = 0; i < 150; i++) begin
      vi = 1'b1; fi = (i == 0 || i == 50); datai = 24'(2000 + i);
      @(negedge clk);
    end
    chk("f3 frm_err pre-reset", 32'(frm_err), 1);
    vi = 1'b0; fi = 1'b0;
    cpu_req = 1'b1; cpu_adr = 9'd7;
    @(negedge clk);
    reset_x = 1'b0;
    vi = 1'b1; datai = 24'(2150);
    #1;
    chk("arst vo", 32'(vo), 0);
    chk("arst fo", 32'(fo), 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst done", 32'(done), 0);
    chk("arst frm_err", 32'(frm_err), 0);
    chk("arst frm_cnt", 32'(frm_cnt), 0);
    chk("arst cpu_ack", 32'(cpu_ack), 0);
    chk("arst cpu_data", 32'(cpu_data), 0);
    cpu_req = 1'b0; vi = 1'b0;
    ack_watch = 1'b1;
    repeat (4) @(negedge clk);
    reset_x = 1'b1;
    repeat (3) @(negedge clk);
    ack_watch = 1'b0;
    chk("arst read dropped", 32'(ack_seen), 0);
    chk("arst ram149", 32'(ram[149]), 2149);
    chk("arst ram150 untouched", 32'(ram[150]), 1150);
    vi = 1'b1; fi = 1'b1; datai = 24'h123;
    #1;
    chk("idle vi&fi no write", 32'(mem_we), 0);
    @(negedge clk);
    vi = 1'b0; fi = 1'b0;
    chk("idle stays idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
